// File: rtl/text_buf_pkg.sv
// Shared definitions for the VGA text buffer path.
//   - Character codes recognised by the cursor writer.
//   - Printable range bounds (inclusive).
//   - Writer FSM state encoding.
package text_buf_pkg;

  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_FF    = 8'h0C;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] PRINT_LO  = 8'h20;
  localparam logic [7:0] PRINT_HI  = 8'h7E;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } writer_state_e;

endpackage

// File: rtl/rise_detect.sv
// Registered single-bit rising-edge detector.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   d     : level input, sampled every clock edge
//   rise  : high while d=1 and the previous sample was 0
// RESET_VAL sets the remembered "previous" level after reset. Resetting it
// to 1 suppresses an event for an input that is already high at release.
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/text_cursor_writer.sv
// Cursor-managed write port for the VGA character buffer.
// Takes UART bytes, writes printable characters at a row/column cursor,
// handles CR/LF/BS, and on form-feed sweeps the whole buffer with spaces.
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   rx_data  : received byte, stable while rx_valid is high
//   rx_valid : byte-ready level; only its rising edge is an event
//   wr_en    : one-cycle RAM write strobe (held high during a sweep)
//   wr_row   : RAM write row
//   wr_col   : RAM write column
//   wr_data  : RAM write data
//   cur_row  : cursor row
//   cur_col  : cursor column
//   busy     : clear sweep in progress
//   dropped  : sticky, a byte event arrived while busy; cleared by reset
// Handshake: a byte is accepted on the clock edge where rx_valid is high and
// was low at the previous edge; there is no back-pressure, so an event seen
// while busy is discarded and recorded in dropped.
module text_cursor_writer
  import text_buf_pkg::*;
#(
  parameter int COLS   = 32,
  parameter int ROWS   = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         rx_data,
  input  logic                      rx_valid,
  output logic                      wr_en,
  output logic [$clog2(ROWS)-1:0]   wr_row,
  output logic [$clog2(COLS)-1:0]   wr_col,
  output logic [DATA_W-1:0]         wr_data,
  output logic [$clog2(ROWS)-1:0]   cur_row,
  output logic [$clog2(COLS)-1:0]   cur_col,
  output logic                      busy,
  output logic                      dropped
);

  localparam int COL_W   = $clog2(COLS);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int POS_W   = ROW_W + COL_W;
  // One extra bit so the counter can reach CELLS, marking "all cells written".
  localparam int SWEEP_W = POS_W + 1;
  localparam int CELLS   = ROWS * COLS;

  localparam logic [DATA_W-1:0] SPACE = DATA_W'(CHR_SPACE);

  logic byte_evt;

  rise_detect #(
    .RESET_VAL (1'b1)
  ) u_rise (
    .clk   (clk),
    .rst_n (reset),
    .d     (rx_valid),
    .rise  (byte_evt)
  );

  writer_state_e       state_q,   state_d;
  logic [SWEEP_W-1:0]  sweep_q,   sweep_d;
  logic [ROW_W-1:0]    cur_row_q, cur_row_d;
  logic [COL_W-1:0]    cur_col_q, cur_col_d;
  logic                wr_en_q,   wr_en_d;
  logic [ROW_W-1:0]    wr_row_q,  wr_row_d;
  logic [COL_W-1:0]    wr_col_q,  wr_col_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q,    busy_d;
  logic                dropped_q, dropped_d;

  // Row-major linear cursor: {row, col} increments/decrements wrap across
  // row boundaries and around the whole screen through natural width wrap.
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_inc;
  logic [POS_W-1:0] pos_dec;
  logic             is_print;

  assign pos      = {cur_row_q, cur_col_q};
  assign pos_inc  = pos + POS_W'(1);
  assign pos_dec  = pos - POS_W'(1);
  assign is_print = (rx_data >= DATA_W'(PRINT_LO)) && (rx_data <= DATA_W'(PRINT_HI));

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    wr_en_d   = 1'b0;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    dropped_d = dropped_q;

    case (state_q)
      IDLE: begin
        if (byte_evt) begin
          if (is_print) begin
            wr_en_d                = 1'b1;
            wr_row_d               = cur_row_q;
            wr_col_d               = cur_col_q;
            wr_data_d              = rx_data;
            {cur_row_d, cur_col_d} = pos_inc;
          end else if (rx_data == DATA_W'(CHR_CR)) begin
            cur_col_d = '0;
          end else if (rx_data == DATA_W'(CHR_LF)) begin
            cur_row_d = cur_row_q + ROW_W'(1);
          end else if (rx_data == DATA_W'(CHR_BS)) begin
            // Backspace stops at the home position; elsewhere it steps back
            // (across a row boundary if needed) and blanks the new cell.
            if (pos != '0) begin
              {cur_row_d, cur_col_d} = pos_dec;
              {wr_row_d, wr_col_d}   = pos_dec;
              wr_data_d              = SPACE;
              wr_en_d                = 1'b1;
            end
          end else if (rx_data == DATA_W'(CHR_FF)) begin
            // The first sweep write (cell 0) is issued on the same edge that
            // raises busy, so wr_en and busy rise and fall together.
            state_d   = CLEAR;
            busy_d    = 1'b1;
            wr_en_d   = 1'b1;
            wr_row_d  = '0;
            wr_col_d  = '0;
            wr_data_d = SPACE;
            sweep_d   = SWEEP_W'(1);
          end
        end
      end

      CLEAR: begin
        if (byte_evt) begin
          dropped_d = 1'b1;
        end
        if (sweep_q == SWEEP_W'(CELLS)) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          sweep_d   = '0;
          cur_row_d = '0;
          cur_col_d = '0;
        end else begin
          wr_en_d              = 1'b1;
          {wr_row_d, wr_col_d} = sweep_q[POS_W-1:0];
          wr_data_d            = SPACE;
          sweep_d              = sweep_q + SWEEP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sweep_q   <= '0;
      cur_row_q <= '0;
      cur_col_q <= '0;
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      wr_en_q   <= wr_en_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_row  = wr_row_q;
  assign wr_col  = wr_col_q;
  assign wr_data = wr_data_q;
  assign cur_row = cur_row_q;
  assign cur_col = cur_col_q;
  assign busy    = busy_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_text_cursor_writer.sv
module tb_text_cursor_writer;

  localparam int W = 15; // {row[1:0], col[4:0], data[7:0]}

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       wr_en;
  logic [1:0] wr_row;
  logic [4:0] wr_col;
  logic [7:0] wr_data;
  logic [1:0] cur_row;
  logic [4:0] cur_col;
  logic       busy;
  logic       dropped;

  int n_cmp;
  int n_err;
  int busy_cnt;
  int mis_cnt;

  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];

  text_cursor_writer #(
    .COLS   (32),
    .ROWS   (4),
    .DATA_W (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .busy     (busy),
    .dropped  (dropped)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (wr_en) got_q.push_back({wr_row, wr_col, wr_data});
      if (busy) busy_cnt++;
      if (wr_en != busy) mis_cnt++;
    end
  end

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [W-1:0] wr(input logic [1:0] r, input logic [4:0] c, input logic [7:0] d);
    return {r, c, d};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    int n0;
    n_cmp = 0;
    n_err = 0;
    busy_cnt = 0;
    mis_cnt = 0;

    // Reset state
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_addr_data", {wr_row, wr_col, wr_data}, 0);
    check("rst_cursor", {cur_row, cur_col}, 0);
    check("rst_busy_dropped", {busy, dropped}, 0);
    apply_reset();

    // "AB" with rx_valid held 5 cycles each
    got_q.delete();
    send_byte(8'h41, 5);
    send_byte(8'h42, 5);
    exp_q.push_back(wr(2'd0, 5'd0, 8'h41));
    exp_q.push_back(wr(2'd0, 5'd1, 8'h42));
    check_writes("ab");
    check("ab_cursor", {cur_row, cur_col}, {2'd0, 5'd2});

    // 33 printable bytes, then 95 more: row advance and full wrap
    apply_reset();
    got_q.delete();
    for (int i = 0; i < 33; i++) send_byte(8'h41 + 8'(i % 26), 1);
    check("p33_count", got_q.size(), 33);
    check("p33_last", got_q[32], wr(2'd1, 5'd0, 8'h47));
    check("p33_cursor", {cur_row, cur_col}, {2'd1, 5'd1});
    for (int i = 33; i < 128; i++) send_byte(8'h41 + 8'(i % 26), 1);
    check("p128_count", got_q.size(), 128);
    check("p128_last", got_q[127], wr(2'd3, 5'd31, 8'h58));
    check("p128_cursor_wrap", {cur_row, cur_col}, 0);
    got_q.delete();

    // Backspace across a row boundary
    apply_reset();
    send_byte(8'h0A, 1);
    send_byte(8'h0A, 1);
    check("bs_pre_cursor", {cur_row, cur_col}, {2'd2, 5'd0});
    got_q.delete();
    send_byte(8'h08, 1);
    exp_q.push_back(wr(2'd1, 5'd31, 8'h20));
    check_writes("bs_wrap");
    check("bs_wrap_cursor", {cur_row, cur_col}, {2'd1, 5'd31});

    // Backspace mid-row
    send_byte(8'h08, 1);
    exp_q.push_back(wr(2'd1, 5'd30, 8'h20));
    check_writes("bs_mid");
    check("bs_mid_cursor", {cur_row, cur_col}, {2'd1, 5'd30});

    // Backspace at home: nothing
    apply_reset();
    got_q.delete();
    send_byte(8'h08, 1);
    check_writes("bs_home");
    check("bs_home_cursor", {cur_row, cur_col}, 0);

    // LF / CR / ignored byte from (3,5)
    apply_reset();
    for (int i = 0; i < 3; i++) send_byte(8'h0A, 1);
    for (int i = 0; i < 5; i++) send_byte(8'h2E, 1);
    check("ctl_pre_cursor", {cur_row, cur_col}, {2'd3, 5'd5});
    got_q.delete();
    send_byte(8'h0A, 1);
    check("lf_cursor", {cur_row, cur_col}, {2'd0, 5'd5});
    send_byte(8'h0D, 1);
    check("cr_cursor", {cur_row, cur_col}, 0);
    send_byte(8'h7E, 1);
    send_byte(8'h07, 1);
    check("bel_cursor", {cur_row, cur_col}, {2'd0, 5'd1});
    send_byte(8'h7F, 1);
    check("del_cursor", {cur_row, cur_col}, {2'd0, 5'd1});
    exp_q.push_back(wr(2'd0, 5'd0, 8'h7E));
    check_writes("ctl");

    // Form feed: full sweep, with a dropped byte during busy
    send_byte(8'h41, 1); // cursor now (0,2)
    got_q.delete();
    check("ff_pre_dropped", dropped, 0);
    busy_cnt = 0;
    mis_cnt  = 0;
    send_byte(8'h0C, 3);
    check("ff_busy_now", busy, 1);
    send_byte(8'h43, 2);
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    check("ff_busy_timeout", busy, 0);
    repeat (2) @(negedge clk);
    check("ff_busy_cycles", busy_cnt, 128);
    check("ff_wr_busy_align", mis_cnt, 0);
    check("ff_write_count", got_q.size(), 128);
    bad = 0;
    for (int i = 0; i < 128 && i < got_q.size(); i++)
      if (got_q[i] !== wr(2'(i / 32), 5'(i % 32), 8'h20)) bad++;
    check("ff_sweep_order", bad, 0);
    check("ff_dropped", dropped, 1);
    check("ff_cursor", {cur_row, cur_col}, 0);
    got_q.delete();
    send_byte(8'h44, 1);
    exp_q.push_back(wr(2'd0, 5'd0, 8'h44));
    check_writes("post_ff");
    check("dropped_sticky", dropped, 1);

    // rx_valid held high across reset release: no event
    reset = 1'b0;
    rx_data = 8'h41;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check_writes("held_valid");
    check("held_cursor", {cur_row, cur_col}, 0);
    check("held_dropped_cleared", dropped, 0);
    send_byte(8'h43, 1);
    exp_q.push_back(wr(2'd0, 5'd0, 8'h43));
    check_writes("after_held");

    // Reset in the middle of a sweep
    send_byte(8'h0C, 1);
    for (int i = 0; i < 200 && got_q.size() < 40; i++) @(negedge clk);
    check("abort_reach40", got_q.size() >= 40, 1);
    #1;
    n0 = got_q.size();
    reset = 1'b0;
    #1;
    check("abort_wr_en", wr_en, 0);
    check("abort_busy", busy, 0);
    check("abort_cursor", {cur_row, cur_col}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_more_writes", got_q.size(), n0);
    check("abort_busy_stays_low", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/text_cursor_writer.md
# text_cursor_writer

Cursor-managed write port for the VGA character buffer. Sits between the UART receiver and the dual-port text RAM. It takes received bytes, interprets printable and control characters, and keeps a row/column cursor. It issues one-cycle RAM write strobes, and on form-feed it runs a full-screen clear sweep.

## Interface
Parameters:
- COLS, 32, characters per row; power of two; COL_W = log2(COLS)
- ROWS, 4, rows in buffer; power of two; ROW_W = log2(ROWS)
- DATA_W, 8, character width

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- rx_data  in  DATA_W  received byte from UART, stable while rx_valid high
- rx_valid  in  1  UART byte-ready level; may stay high for many cycles; only its rising edge counts
- wr_en  out  1  RAM write enable, one-cycle pulse per write
- wr_row  out  ROW_W  RAM write row address
- wr_col  out  COL_W  RAM write column address
- wr_data  out  DATA_W  RAM write data
- cur_row  out  ROW_W  current cursor row
- cur_col  out  COL_W  current cursor column
- busy  out  1  high while clear sweep runs
- dropped  out  1  sticky flag: a byte arrived during busy and was discarded

## Operation
- Edge detect: the previous rx_valid is registered as prev_valid. A byte event is rx_valid=1 and prev_valid=0 at a clk edge.
- FSM states: IDLE, CLEAR.
- IDLE, event handling by rx_data:
  - 0x20–0x7E (printable):
    - write rx_data at the cursor;
    - advance col;
    - at col COLS-1, go to col 0 and row+1;
    - at (ROWS-1, COLS-1), wrap to (0,0).
  - 0x0D CR: col to 0, no write.
  - 0x0A LF: row+1, wrapping ROWS-1 to 0; col unchanged; no write.
  - 0x08 BS:
    - col>0: col-1, then write 0x20 at the new position;
    - col=0 and row>0: move to (row-1, COLS-1) and write 0x20 there;
    - (0,0): no action.
  - 0x0C FF: enter CLEAR and raise busy.
  - Any other byte: ignored; cursor unchanged.
- CLEAR:
  - Sweep index i = 0 .. ROWS*COLS-1, row-major (row = i / COLS, col = i mod COLS).
  - One write of 0x20 per cycle, wr_en held high throughout.
  - After the last write: cursor (0,0), busy low, back to IDLE.
- Byte event while in CLEAR: discarded, and dropped set to 1. dropped clears only on reset.
- Address and cursor arithmetic is modulo COLS/ROWS via natural width wrap; no out-of-range address is ever driven.

## Timing
- All outputs are registered.
- On reset assertion, asynchronously:
  - wr_en=0, wr_row=0, wr_col=0, wr_data=0;
  - cur_row=0, cur_col=0, busy=0, dropped=0;
  - state IDLE;
  - prev_valid=1, so an rx_valid already high at release is not taken as an event.
- Latency: an event sampled at edge k gives wr_en=1, with address and data, during the cycle after edge k, for exactly one cycle. cur_row/cur_col show the updated position from edge k as well.
- The write address is the pre-advance cursor for printable characters and the post-move cursor for BS.
- FF sampled at edge k:
  - busy=1 from edge k;
  - sweep writes occupy cycles k+1 .. k+ROWS*COLS (128 cycles at defaults);
  - busy=0 and cursor (0,0) after edge k+ROWS*COLS.
- Minimum event spacing is 2 cycles, because rx_valid must go low for at least one sampled cycle.
- Reset asserted mid-sweep aborts the sweep immediately; no further writes.

## Structure
- Shared package text_buf_pkg holds:
  - character constants CHR_CR, CHR_LF, CHR_BS, CHR_FF, CHR_SPACE, PRINT_LO, PRINT_HI;
  - the state enum {IDLE, CLEAR}.
- Natural sub-module: rise_detect (single-bit registered rising-edge detector, configurable reset value). Used once here; reusable for other strobes in the design.
- Cursor advance and sweep counter stay inline in text_cursor_writer.

## Test plan
- Reset, then bytes "AB" (0x41, 0x42) with rx_valid held 5 cycles each -> exactly two writes, (0,0)=0x41 and (0,1)=0x42; cursor ends (0,2).
- 33 printable bytes from reset -> the 33rd write goes to (1,0); then 95 more bytes -> the last write goes to (3,31) and the cursor wraps to (0,0).
- Cursor at (2,0), send 0x08 -> write 0x20 at (1,31), cursor (1,31). At (0,0), send 0x08 -> no write, cursor unchanged.
- Cursor at (3,5):
  - send 0x0A -> cursor (0,5), no write;
  - send 0x0D -> cursor (0,0), no write;
  - send 0x07 -> ignored.
- Send 0x0C:
  - busy high exactly 128 cycles, with 128 consecutive writes of 0x20 covering every cell once, in row-major order;
  - a byte event during busy sets dropped and causes no extra write.
- rx_valid held high across reset release -> no write. Reset asserted at sweep cycle 40 -> wr_en and busy low immediately, cursor (0,0).
